// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue: fetches the byte at the current IP, buffers up to
// DEPTH bytes in a circular FIFO and presents the oldest byte show-ahead to the decoder.
module prefetch_queue #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      ip_in,
  output logic             load_ip,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_data,
  input  logic             flush,
  output logic             q_valid,
  output logic [7:0]       q_data,
  input  logic             q_pop,
  output logic [CNT_W-1:0] q_count
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ADV  = 2'd2
  } state_e;

  state_e           state_q;
  logic             mem_req_q;
  logic [15:0]      mem_addr_q;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_c;
  logic             pop_c;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Flush wins over both queue operations; an ack in the flush cycle is dropped.
  assign push_c = (state_q == REQ) && mem_ack && !flush;
  assign pop_c  = q_pop && (count_q != '0) && !flush;

  // Fetch sequencer: one outstanding read, issued only when there is room for its byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (flush) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q < FULL_CNT) begin
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= ip_in;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q   <= ADV;
            mem_req_q <= 1'b0;
          end
        end
        ADV: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Queue bookkeeping; push and pop in the same cycle leave the count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage needs no reset: contents are only visible behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push_c && !reset) mem_q[wr_ptr_q] <= mem_data;
  end

  // load_ip is gated by flush in the same cycle so a redirect never sees a stray increment.
  assign load_ip  = (state_q == ADV) && !flush;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign q_valid  = (count_q != '0);
  assign q_data   = mem_q[rd_ptr_q];
  assign q_count  = count_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: IP register, memory responder and a byte-queue reference model
// live here; each task drives one scenario and checks the DUT against the model and constants.
module tb_prefetch_queue;

  localparam int unsigned DEPTH = 6;
  localparam int unsigned CNT_W = 3;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             flush   = 1'b0;
  logic             q_pop   = 1'b0;
  logic             mem_ack = 1'b0;
  logic [15:0]      ip_tb   = 16'h0000;
  logic             load_ip, mem_req, q_valid;
  logic [15:0]      mem_addr;
  logic [7:0]       mem_data, q_data;
  logic [CNT_W-1:0] q_count;

  assign mem_data = mem_addr[7:0];

  prefetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .ip_in   (ip_tb),
    .load_ip (load_ip),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_data(mem_data),
    .flush   (flush),
    .q_valid (q_valid),
    .q_data  (q_data),
    .q_pop   (q_pop),
    .q_count (q_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: bytes in the queue, popped history, and whether an advance is due.
  logic [7:0] exp_q[$];
  logic [7:0] popped[$];
  logic       pending    = 1'b0;
  int         wcnt       = 0;
  int         cur_wait   = 0;
  int         wait_fixed = 0;
  int         wait_max   = 0;
  int         loads      = 0;

  logic             s_req, s_load, s_valid;
  logic [15:0]      s_addr;
  logic [7:0]       s_data;
  logic [CNT_W-1:0] s_cnt;

  // One clock: respond as memory, drive inputs, sample outputs, check, then advance the model.
  task automatic cycle(input int fl_mode, input int pop_mode, input int ack_mode,
                       input logic [15:0] redir, output logic fired);
    logic ack, pop, fl, push;
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (wcnt == 0)
        cur_wait = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(wait_max, 0));
      ack = (wcnt >= cur_wait);
      wcnt++;
    end else begin
      ack  = 1'b0;
      wcnt = 0;
    end
    if (ack_mode == 1) ack = 1'b1;
    else if (ack_mode == 2) ack = 1'b0;
    case (fl_mode)
      1:       fl = 1'b1;
      2:       fl = mem_req;
      3:       fl = pending;
      4:       fl = ($urandom_range(49, 0) == 0);
      default: fl = 1'b0;
    endcase
    case (pop_mode)
      1:       pop = 1'b1;
      2:       pop = ($urandom_range(1, 0) == 1);
      3:       pop = ack && mem_req;
      5:       pop = ($urandom_range(5, 0) == 0);
      default: pop = 1'b0;
    endcase
    reset   = 1'b0;
    flush   = fl;
    q_pop   = pop;
    mem_ack = ack;
    #1;
    s_req = mem_req; s_addr = mem_addr; s_load = load_ip;
    s_valid = q_valid; s_data = q_data; s_cnt = q_count;

    tests++;
    if (s_cnt !== CNT_W'(exp_q.size())) begin
      fails++; $display("FAIL q_count: got %0d want %0d", s_cnt, exp_q.size());
    end
    tests++;
    if (s_valid !== (exp_q.size() != 0)) begin
      fails++; $display("FAIL q_valid: got %b want %b", s_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      tests++;
      if (s_data !== exp_q[0]) begin
        fails++; $display("FAIL q_data: got %h want %h", s_data, exp_q[0]);
      end
    end
    if (s_req) begin
      tests++;
      if (s_addr !== ip_tb) begin
        fails++; $display("FAIL mem_addr: got %h want %h", s_addr, ip_tb);
      end
    end
    tests++;
    if (s_load !== (pending && !fl)) begin
      fails++; $display("FAIL load_ip: got %b want %b", s_load, pending && !fl);
    end

    push = s_req && ack && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop && exp_q.size() != 0) popped.push_back(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(ip_tb[7:0]);
        tests++;
        if (exp_q.size() > DEPTH) begin
          fails++; $display("FAIL overflow: got %0d bytes want at most %0d", exp_q.size(), DEPTH);
        end
      end
    end
    pending = push;
    if (s_load) loads++;
    if (fl) ip_tb = redir;
    else if (s_load) ip_tb = ip_tb + 16'd1;
    fired = fl;
  endtask

  task automatic step(input int pop_mode);
    logic f;
    cycle(0, pop_mode, 0, ip_tb, f);
  endtask

  task automatic check_guard(input int g, input int lim, input string what);
    tests++;
    if (g >= lim) begin
      fails++; $display("FAIL %s: got timeout after %0d cycles want event", what, g);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; flush = 1'b0; q_pop = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete(); popped.delete();
    pending = 1'b0; wcnt = 0; loads = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst mem_req: got %b want 0", mem_req); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL rst mem_addr: got %h want 0000", mem_addr); end
    tests++; if (load_ip !== 1'b0) begin fails++; $display("FAIL rst load_ip: got %b want 0", load_ip); end
    tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL rst q_valid: got %b want 0", q_valid); end
    tests++; if (q_count !== '0) begin fails++; $display("FAIL rst q_count: got %0d want 0", q_count); end
  endtask

  task automatic test_cold_fill();
    logic [CNT_W-1:0] cnt_h[40];
    logic             req_h[40];
    logic             f;
    int               nreq = 0;
    int               late = 0;
    ip_tb = 16'h0000; wait_fixed = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 1, ip_tb, f);
      cnt_h[i] = s_cnt; req_h[i] = s_req;
      if (s_req) nreq++;
      if (s_req && i >= 18) late++;
    end
    tests++; if (req_h[0] !== 1'b0 || req_h[1] !== 1'b1) begin fails++; $display("FAIL fill first req: got %b%b want 01", req_h[0], req_h[1]); end
    tests++; if (cnt_h[16] !== 3'd5) begin fails++; $display("FAIL fill count c16: got %0d want 5", cnt_h[16]); end
    tests++; if (cnt_h[17] !== 3'd6) begin fails++; $display("FAIL fill count c17: got %0d want 6", cnt_h[17]); end
    tests++; if (loads != 6) begin fails++; $display("FAIL fill load_ip pulses: got %0d want 6", loads); end
    tests++; if (nreq != 6) begin fails++; $display("FAIL fill req cycles: got %0d want 6", nreq); end
    tests++; if (late != 0) begin fails++; $display("FAIL fill req after full: got %0d cycles want 0", late); end
    tests++; if (ip_tb !== 16'h0006) begin fails++; $display("FAIL fill ip: got %h want 0006", ip_tb); end
  endtask

  task automatic test_drain_wrap();
    int g = 0;
    popped.delete();
    wait_fixed = -1; wait_max = 2;
    for (int i = 0; i < 4; i++) step(1);
    while (popped.size() < 20 && g < 400) begin step(2); g++; end
    check_guard(g, 400, "drain 20 bytes");
    for (int i = 0; i < 20; i++) begin
      if (i < popped.size()) begin
        tests++;
        if (popped[i] !== 8'(i)) begin fails++; $display("FAIL drain byte %0d: got %h want %h", i, popped[i], 8'(i)); end
      end
    end
  endtask

  task automatic test_concurrent();
    int g = 0;
    int bad = 0;
    ip_tb = 16'h0100; wait_fixed = 0;
    do_reset();
    while (exp_q.size() < 5 && g < 100) begin step(0); g++; end
    check_guard(g, 100, "fill to 5");
    for (int i = 0; i < 30; i++) begin
      step(3);
      if (s_cnt !== 3'd5) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL push+pop at 5: got %0d cycles off 5 want 0", bad); end
    g = 0;
    while (exp_q.size() < 6 && g < 100) begin step(0); g++; end
    check_guard(g, 100, "fill to 6");
    bad = 0;
    for (int i = 0; i < 3; i++) begin step(0); if (s_req !== 1'b0) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL stall when full: got %0d req cycles want 0", bad); end
    step(1);
    step(3);
    tests++; if (s_cnt !== 3'd5 || s_req !== 1'b0) begin fails++; $display("FAIL after pop: got cnt %0d req %b want 5 0", s_cnt, s_req); end
    step(3);
    tests++; if (s_req !== 1'b1) begin fails++; $display("FAIL refetch after pop: got req %b want 1", s_req); end
    for (int i = 0; i < 18; i++) step(3);
    tests++; if (s_cnt !== 3'd5) begin fails++; $display("FAIL push+pop from full: got %0d want 5", s_cnt); end
    for (int i = 0; i < popped.size(); i++) begin
      tests++;
      if (popped[i] !== 8'(i)) begin fails++; $display("FAIL order byte %0d: got %h want %h", i, popped[i], 8'(i)); end
    end
  endtask

  task automatic test_wait_states();
    logic        rq[50];
    logic [15:0] ad[50];
    logic [15:0] a0 = 16'h0;
    int          runs = 0;
    int          len = 0;
    ip_tb = 16'h2000; wait_fixed = 3;
    do_reset();
    for (int i = 0; i < 50; i++) begin step(0); rq[i] = s_req; ad[i] = s_addr; end
    for (int i = 0; i < 50; i++) begin
      if (rq[i]) begin
        if (len == 0) a0 = ad[i];
        else begin
          tests++;
          if (ad[i] !== a0) begin fails++; $display("FAIL addr stable c%0d: got %h want %h", i, ad[i], a0); end
        end
        len++;
      end else if (len > 0) begin
        tests++;
        if (len != 4) begin fails++; $display("FAIL req length: got %0d want 4", len); end
        runs++; len = 0;
      end
    end
    tests++; if (runs != 6) begin fails++; $display("FAIL wait fetches: got %0d want 6", runs); end
    tests++; if (loads != 6) begin fails++; $display("FAIL wait load_ip: got %0d want 6", loads); end
  endtask

  task automatic test_flush();
    logic f = 1'b0;
    int   g = 0;
    int   l0;
    ip_tb = 16'h0300; wait_fixed = 0;
    do_reset();
    while (exp_q.size() < 2 && g < 50) begin step(0); g++; end
    check_guard(g, 50, "pre-flush fill");
    g = 0; l0 = loads;
    while (!f && g < 10) begin l0 = loads; cycle(2, 0, 1, 16'h1234, f); g++; end
    check_guard(g, 10, "flush in REQ");
    tests++; if (loads != l0) begin fails++; $display("FAIL REQ flush load_ip: got %0d pulses want %0d", loads, l0); end
    step(0);
    tests++; if (s_cnt !== '0 || s_valid !== 1'b0) begin fails++; $display("FAIL REQ flush empty: got %0d/%b want 0/0", s_cnt, s_valid); end
    g = 0;
    while (!s_req && g < 10) begin step(0); g++; end
    check_guard(g, 10, "refetch after REQ flush");
    tests++; if (s_addr !== 16'h1234) begin fails++; $display("FAIL redirect addr: got %h want 1234", s_addr); end
    tests++; if (loads != l0) begin fails++; $display("FAIL load_ip after flush: got %0d want %0d", loads, l0); end
    f = 1'b0; g = 0;
    while (!f && g < 10) begin l0 = loads; cycle(3, 0, 0, 16'h4000, f); g++; end
    check_guard(g, 10, "flush in ADV");
    tests++; if (loads != l0) begin fails++; $display("FAIL ADV flush load_ip: got %0d pulses want %0d", loads, l0); end
    step(0);
    tests++; if (s_cnt !== '0) begin fails++; $display("FAIL ADV flush count: got %0d want 0", s_cnt); end
    g = 0;
    while (!s_req && g < 10) begin step(0); g++; end
    check_guard(g, 10, "refetch after ADV flush");
    tests++; if (s_addr !== 16'h4000) begin fails++; $display("FAIL ADV redirect addr: got %h want 4000", s_addr); end
    g = 0;
    while (!s_valid && g < 10) begin step(0); g++; end
    check_guard(g, 10, "byte after ADV flush");
    tests++; if (s_data !== 8'h00) begin fails++; $display("FAIL byte after flush: got %h want 00", s_data); end
  endtask

  task automatic test_pop_empty();
    int g = 0;
    int bad = 0;
    ip_tb = 16'h0055; wait_fixed = 4;
    do_reset();
    for (int i = 0; i < 4; i++) begin step(1); if (s_cnt !== '0) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL pop empty count: got %0d nonzero cycles want 0", bad); end
    while (!s_valid && g < 20) begin step(0); g++; end
    check_guard(g, 20, "first byte after empty pops");
    tests++; if (s_data !== 8'h55 || s_cnt !== 3'd1) begin fails++; $display("FAIL pop empty byte: got %h/%0d want 55/1", s_data, s_cnt); end
  endtask

  task automatic test_random();
    logic f;
    ip_tb = 16'($urandom); wait_fixed = -1; wait_max = 3;
    do_reset();
    for (int i = 0; i < 750; i++) cycle(4, 2, 0, 16'($urandom), f);
    for (int i = 0; i < 750; i++) cycle(4, 5, 0, 16'($urandom), f);
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_drain_wrap();
    test_concurrent();
    test_wait_states();
    test_flush();
    test_pop_empty();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got time limit want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "simulation time limit");
  end

endmodule
